// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the serial arithmetic blocks: FSM state
// encoding and the bit-counter width helper.
package serial_arith_pkg;

  // Plain constants for tools that cannot consume the enum type directly.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  // Bit-counter width; never narrower than one bit.
  function automatic int cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder built from two half adders and an OR, used as the
// single arithmetic slice of the serial adder.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic co
);
  assign s  = a ^ b;
  assign co = a & b;
endmodule

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);
  logic s1;
  logic c1;
  logic c2;

  half_adder u_ha0 (.a(a),  .b(b),   .s(s1), .co(c1));
  half_adder u_ha1 (.a(s1), .b(cin), .s(s),  .co(c2));

  // The two half-adder carries can never both be set, so OR gives majority.
  assign co = c1 | c2;
endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one bit per clock, LSB first, registered carry.
// Optional macro SERIAL_SUB_MODE_EN adds a 'sub' input for a-b.
module bit_serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_SUB_MODE_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] s_sh_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic [CW-1:0]    cnt_reg;

  logic             sum_bit;
  logic             carry_next;
  logic             last_bit;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

`ifdef SERIAL_SUB_MODE_EN
  // Subtraction as a + ~b + 1; cout then reads as NOT borrow.
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  full_adder_cell u_fa (
    .a  (a_sh_reg[0]),
    .b  (b_sh_reg[0]),
    .cin(carry_reg),
    .s  (sum_bit),
    .co (carry_next)
  );

  assign last_bit = (cnt_reg == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      s_sh_reg  <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_sh_reg  <= a;
            b_sh_reg  <= b_load;
            carry_reg <= c_load;
            cnt_reg   <= '0;
          end
        end
        RUN: begin
          a_sh_reg  <= {1'b0, a_sh_reg[WIDTH-1:1]};
          b_sh_reg  <= {1'b0, b_sh_reg[WIDTH-1:1]};
          s_sh_reg  <= {sum_bit, s_sh_reg[WIDTH-1:1]};
          carry_reg <= carry_next;
          cnt_reg   <= cnt_reg + 1'b1;
          // Publish the result on the edge that consumes the final bit.
          if (last_bit) begin
            sum_reg  <= {sum_bit, s_sh_reg[WIDTH-1:1]};
            cout_reg <= carry_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Scoreboard bench for bit_serial_adder (WIDTH=8); sub-mode vectors are
// applied only when SERIAL_SUB_MODE_EN is defined.
module tb_bit_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub_in = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         held = '0;
  logic         prev_done = 1'b0;
  int           n_checks = 0;
  int           n_errors = 0;

  always #5 clk = ~clk;

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
`ifdef SERIAL_SUB_MODE_EN
    .sub  (sub_in),
`endif
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv, input logic sv);
    logic [W:0] full;
    full = {1'b0, av} + {1'b0, (sv ? ~bv : bv)} + {{W{1'b0}}, (sv ? 1'b1 : cv)};
    exp_q.push_back('{s: full[W-1:0], c: full[W]});
  endtask

  // Scoreboard: pop on done; results must stay frozen while busy.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_done", 64'(done), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_val("sum", 64'(sum), 64'(e.s));
        check_val("cout", 64'(cout), 64'(e.c));
        $display("result sum=0x%02h cout=%0d (want 0x%02h/%0d)", sum, cout, e.s, e.c);
        held = e;
      end
      if (prev_done) check_val("done_pulse_width", 64'(done), 64'd0);
    end else if (busy) begin
      check_val("sum_held", 64'(sum), 64'(held.s));
      check_val("cout_held", 64'(cout), 64'(held.c));
    end
    prev_done = done;
  end

  task automatic wait_done(output int n_busy, output bit got);
    n_busy = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
      else if (busy) n_busy++;
    end
    check_val("done_seen", 64'(got), 64'd1);
  endtask

  // restart_at > 0 re-pulses start with other operands at that RUN negedge.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        input logic sv, input int restart_at);
    int n_busy;
    bit got;
    push_exp(av, bv, cv, sv);
    @(negedge clk);
    a = av; b = bv; cin = cv; sub_in = sv; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = ~cv;
    n_busy = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
      end else begin
        if (busy) n_busy++;
        if (restart_at > 0 && i == restart_at) begin
          a = 8'h11; b = 8'h22; start = 1'b1;
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check_val("done_seen", 64'(got), 64'd1);
    check_val("latency", 64'(n_busy), 64'(W));
    @(negedge clk);
    check_val("done_clear", 64'(done), 64'd0);
    check_val("busy_idle", 64'(busy), 64'd0);
    $display("op a=0x%02h b=0x%02h cin=%0d sub=%0d busy_cycles=%0d", av, bv, cv, sv, n_busy);
  endtask

  initial begin
    int  n_busy;
    bit  got;

    repeat (2) @(negedge clk);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_sum", 64'(sum), 64'd0);
    check_val("rst_cout", 64'(cout), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'h3C, 8'h5A, 1'b0, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0, 0);
    // Start re-pulsed so it is sampled at edge 3 of the run: must be ignored.
    run_op(8'h3C, 8'h5A, 1'b0, 1'b0, 2);

    // Start held high through DONE: second op begins only after IDLE.
    push_exp(8'h10, 8'h20, 1'b0, 1'b0);
    push_exp(8'h10, 8'h20, 1'b0, 1'b0);
    @(negedge clk);
    a = 8'h10; b = 8'h20; cin = 1'b0; sub_in = 1'b0; start = 1'b1;
    wait_done(n_busy, got);
    @(negedge clk);
    check_val("held_start_idle", 64'(busy), 64'd0);
    @(negedge clk);
    check_val("held_start_run", 64'(busy), 64'd1);
    start = 1'b0;
    wait_done(n_busy, got);
    check_val("held_start_latency", 64'(n_busy), 64'(W - 1));
    @(negedge clk);
    $display("op held-start a=0x10 b=0x20 second_run_seen=%0d", got);

    // Back-to-back: 0x30 must stay visible during the next RUN.
    run_op(8'h80, 8'h80, 1'b0, 1'b0, 0);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    a = 8'h3C; b = 8'h5A; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("abort_busy", 64'(busy), 64'd0);
    check_val("abort_done", 64'(done), 64'd0);
    check_val("abort_sum", 64'(sum), 64'd0);
    check_val("abort_cout", 64'(cout), 64'd0);
    held = '0;
    $display("op abort mid-run busy=%0d sum=0x%02h", busy, sum);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(8'h01, 8'h01, 1'b0, 1'b0, 0);

    for (int k = 0; k < 6; k++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 0);
    end

`ifdef SERIAL_SUB_MODE_EN
    run_op(8'h05, 8'h07, 1'b0, 1'b1, 0);
    run_op(8'h07, 8'h05, 1'b0, 1'b1, 0);
    run_op(8'h07, 8'h05, 1'b1, 1'b0, 0);
`endif

    repeat (2) @(negedge clk);
    check_val("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bit_serial_adder.md
Name: bit_serial_adder

Overview:
- Bit-serial ripple adder, the additive counterpart of the team's combinational full subtractor.
- Processes one bit per clock, LSB first, through a single full-adder cell with a registered carry.
- Operands load in parallel on a start handshake. Result is presented in parallel with a one-cycle done pulse.
- Sits in the arithmetic library as an area-minimal adder for multi-cycle datapaths.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock, sole clock domain
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A, captured when start is accepted
- b  input  WIDTH  operand B, captured when start is accepted
- cin  input  1  carry-in, captured when start is accepted
- busy  output  1  high while bits are being processed (RUN)
- done  output  1  one-cycle pulse; sum/cout valid from this cycle
- sum  output  WIDTH  registered result, held until the next completion
- cout  output  1  registered carry-out, held until the next completion

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset: state=IDLE; busy=0, done=0, sum=0, cout=0; internal shift registers, carry flop and bit counter all 0. Reset deasserts synchronously to clk; external synchroniser is assumed by the integrator.
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN: on an edge with start=1.
  - a and b are loaded into shift registers, cin into the carry flop, and the bit counter is cleared.
- RUN, each edge:
  - sum_bit = a_sh[0] ^ b_sh[0] ^ carry.
  - carry <= majority(a_sh[0], b_sh[0], carry).
  - a_sh and b_sh shift right by 1; sum_bit shifts into the MSB of the sum shift register.
  - The bit counter increments.
- RUN → DONE: on the edge that processes bit WIDTH-1. On that same edge, sum and cout load from the shift register and carry.
- DONE → IDLE: unconditionally on the next edge.
- busy is 1 exactly in RUN. done is 1 exactly in DONE.
- Latency: start sampled at edge 0 → done high after edge WIDTH and low after edge WIDTH+1. Throughput is one operation per WIDTH+2 cycles.
- start while in RUN or DONE: ignored, with no queueing. start must be re-asserted in IDLE.
- a, b and cin changes after acceptance: no effect.
- sum and cout are unchanged during RUN; they keep the previous result.
- Arithmetic: the result is the modulo-2^WIDTH sum. cout is bit WIDTH of a+b+cin.
- Reset mid-operation: immediate abort to the reset values; the partial result is discarded.
- Counter width: $clog2(WIDTH), saturation not needed since terminal count = WIDTH-1.

Optional Feature:
- Macro SERIAL_SUB_MODE_EN.
- Defined:
  - Adds input port sub (1 bit), captured with the operands.
  - When sub=1, b is inverted bitwise at load and the carry flop is loaded with 1 (cin ignored), so the result is a-b mod 2^WIDTH.
  - cout then reports NOT borrow (1 = no borrow).
  - When sub=0, behaviour is identical to the undefined case.
- Undefined: no sub port; add only.

Decomposition:
- Package serial_arith_pkg holds:
  - the state enum type (IDLE, RUN, DONE, 2-bit encoding);
  - localparam CNT_W function helper;
  - constants ST_IDLE/ST_RUN/ST_DONE for non-SV tools.
- One sub-module is natural: full_adder_cell (inputs a, b, cin; outputs s, co), built from two instances of the existing half adder plus an OR. It is instantiated once for the serial bit slice.

Test Plan:
- WIDTH=8, a=0x3C, b=0x5A, cin=0, start at edge 0 → busy edges 1..8, done pulse after edge 8, sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- start re-pulsed at edge 3 with a=0x11, b=0x22 during RUN of 0x3C+0x5A → ignored; result still 0x96. A start held high through DONE begins a new operation only at the edge after returning to IDLE.
- rst_n low at edge 4 of an operation → busy/done/sum/cout=0 immediately (asynchronously). A fresh start of 0x01+0x01 after release → sum=0x02.
- Back-to-back: 0x10+0x20 then 0x80+0x80 → first sum 0x30/cout 0 held through the second RUN, then 0x00/cout 1.
- With SERIAL_SUB_MODE_EN: sub=1, a=0x05, b=0x07 → sum=0xFE, cout=0 (borrow); a=0x07, b=0x05 → sum=0x02, cout=1.
